// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispenser: state encoding, default limits
// and the saturating pending-counter update used by the dispenser and the coin FSM.
package vend_pkg;

  localparam int unsigned TIMEOUT_DEF  = 16;
  localparam int unsigned PEND_MAX_DEF = 3;
  localparam int unsigned PEND_W       = 2;

  typedef logic [PEND_W-1:0] pend_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VEND  = 2'd1,
    ST_PAY   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef struct packed {
    pend_t cnt;
    logic  drop;
  } pend_upd_t;

  // Simultaneous increment and decrement cancel; an increment at the limit is dropped.
  function automatic pend_upd_t pend_step(pend_t cnt, logic inc, logic dec, pend_t lim);
    pend_upd_t upd;
    upd.cnt  = cnt;
    upd.drop = 1'b0;
    if (inc && !dec) begin
      if (cnt == lim) upd.drop = 1'b1;
      else            upd.cnt  = cnt + pend_t'(1);
    end else if (dec && !inc && cnt != '0) begin
      upd.cnt = cnt - pend_t'(1);
    end
    return upd;
  endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// Request/sensor/status bundle between the coin FSM side (master) and the
// dispenser (slave).
interface vend_dispenser_if;

  logic              dispense_req;
  logic              change_req;
  logic              bottle_drop;
  logic              coin_out;
  logic              fault_clr;
  logic              motor_on;
  logic              hopper_on;
  logic              busy;
  logic              fault;
  logic              overflow;
  vend_pkg::pend_t   vend_pend;
  vend_pkg::pend_t   chg_pend;

  modport master (
    output dispense_req, change_req, bottle_drop, coin_out, fault_clr,
    input  motor_on, hopper_on, busy, fault, overflow, vend_pend, chg_pend
  );

  modport slave (
    input  dispense_req, change_req, bottle_drop, coin_out, fault_clr,
    output motor_on, hopper_on, busy, fault, overflow, vend_pend, chg_pend
  );

endinterface

// File: rtl/vend_timer.sv
// Actuator watchdog: counts cycles since the last restart and flags the
// final cycle of the allowed window. Holds at that value until restarted.
module vend_timer #(
  parameter int unsigned TIMEOUT = vend_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef logic [W-1:0] cnt_t;

  localparam cnt_t LAST = cnt_t'(TIMEOUT - 1);

  cnt_t r_count;
  logic w_at_last;

  assign w_at_last = (r_count == LAST);
  assign expired   = w_at_last;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (restart) begin
      r_count <= '0;
    end else if (!w_at_last) begin
      r_count <= r_count + cnt_t'(1);
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Bottle/change dispenser: queues vend and change requests, drives the bottle
// motor and coin hopper one job at a time, and latches FAULT on a stuck actuator.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned PEND_MAX = PEND_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  vend_dispenser_if.slave  bus
);

  localparam pend_t PEND_LIM = pend_t'(PEND_MAX);

  state_t    r_state;
  state_t    w_next_state;
  logic      r_motor_on;
  logic      r_hopper_on;
  logic      r_busy;
  logic      r_fault;
  logic      r_overflow;
  pend_t     r_vend_pend;
  pend_t     r_chg_pend;

  logic      w_motor_on;
  logic      w_hopper_on;
  logic      w_busy;
  logic      w_fault;
  logic      w_expired;
  logic      w_restart;
  logic      w_clr;
  logic      w_vend_inc;
  logic      w_chg_inc;
  logic      w_vend_dec;
  logic      w_chg_dec;
  pend_upd_t w_vend_upd;
  pend_upd_t w_chg_upd;

  // Timer restarts on every entry into an actuator state, including VEND -> PAY.
  assign w_restart = (w_next_state != r_state) &&
                     ((w_next_state == ST_VEND) || (w_next_state == ST_PAY));

  vend_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .expired (w_expired)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_vend_pend != '0)     w_next_state = ST_VEND;
        else if (r_chg_pend != '0) w_next_state = ST_PAY;
      end
      ST_VEND: begin
        if (bus.bottle_drop) w_next_state = (r_chg_pend != '0) ? ST_PAY : ST_IDLE;
        else if (w_expired)  w_next_state = ST_FAULT;
      end
      ST_PAY: begin
        if (bus.coin_out)   w_next_state = ST_IDLE;
        else if (w_expired) w_next_state = ST_FAULT;
      end
      ST_FAULT: begin
        if (bus.fault_clr) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    w_motor_on  = (w_next_state == ST_VEND);
    w_hopper_on = (w_next_state == ST_PAY);
    w_busy      = (w_next_state != ST_IDLE);
    w_fault     = (w_next_state == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_motor_on  <= 1'b0;
      r_hopper_on <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_motor_on  <= w_motor_on;
      r_hopper_on <= w_hopper_on;
      r_busy      <= w_busy;
      r_fault     <= w_fault;
    end
  end

  // Sensors only count in the state whose actuator they belong to.
  assign w_vend_inc = bus.dispense_req;
  assign w_chg_inc  = bus.dispense_req & bus.change_req;
  assign w_vend_dec = (r_state == ST_VEND) & bus.bottle_drop;
  assign w_chg_dec  = (r_state == ST_PAY)  & bus.coin_out;
  assign w_clr      = (r_state == ST_FAULT) & bus.fault_clr;

  assign w_vend_upd = pend_step(r_vend_pend, w_vend_inc, w_vend_dec, PEND_LIM);
  assign w_chg_upd  = pend_step(r_chg_pend,  w_chg_inc,  w_chg_dec,  PEND_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vend_pend <= '0;
      r_chg_pend  <= '0;
      r_overflow  <= 1'b0;
    end else if (w_clr) begin
      r_vend_pend <= '0;
      r_chg_pend  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_vend_pend <= w_vend_upd.cnt;
      r_chg_pend  <= w_chg_upd.cnt;
      r_overflow  <= r_overflow | w_vend_upd.drop | w_chg_upd.drop;
    end
  end

  assign bus.motor_on  = r_motor_on;
  assign bus.hopper_on = r_hopper_on;
  assign bus.busy      = r_busy;
  assign bus.fault     = r_fault;
  assign bus.overflow  = r_overflow;
  assign bus.vend_pend = r_vend_pend;
  assign bus.chg_pend  = r_chg_pend;

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles an actuator may stay on without its completion sensor firing.
REQ-002 Parameter PEND_MAX, default 3: saturation value of each pending-request counter.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 dispense_req  input  1  one-cycle pulse from the coin FSM: deliver one bottle.
REQ-006 change_req  input  1  one-cycle pulse, valid only with dispense_req: return one quarter.
REQ-007 bottle_drop  input  1  bottle-chute sensor, high one or more cycles when a bottle falls.
REQ-008 coin_out  input  1  hopper sensor, high when a quarter is ejected.
REQ-009 fault_clr  input  1  operator clear of the fault state.
REQ-010 motor_on  output  1  bottle motor drive.
REQ-011 hopper_on  output  1  coin hopper drive.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 fault  output  1  high in FAULT.
REQ-014 overflow  output  1  sticky: a request was dropped at saturation.
REQ-015 vend_pend  output  2  pending bottle count.
REQ-016 chg_pend  output  2  pending change count.

Function
REQ-017 The block SHALL be a Moore FSM with states IDLE, VEND, PAY, FAULT; motor_on=1 only in VEND, hopper_on=1 only in PAY, all outputs registered.
REQ-018 A cycle with dispense_req=1 SHALL increment vend_pend at that edge; if change_req=1 in the same cycle, chg_pend SHALL also increment.
REQ-019 change_req without dispense_req SHALL be ignored.
REQ-020 An increment on a counter at PEND_MAX SHALL be dropped, leave the counter unchanged and set overflow.
REQ-021 Increment and decrement of the same counter in the same cycle SHALL leave it unchanged.
REQ-022 IDLE: vend_pend!=0 -> VEND; else chg_pend!=0 -> PAY; else stay. Vend has priority.
REQ-023 Latency: request at cycle n, counter updated at edge n, motor_on high after edge n+1.
REQ-024 On entry to VEND or PAY the timeout timer SHALL restart at 0 and count one per cycle.
REQ-025 VEND with bottle_drop=1: vend_pend decrements; next state PAY if chg_pend!=0, else IDLE.
REQ-026 PAY with coin_out=1: chg_pend decrements; next state IDLE.
REQ-027 Timer reaching TIMEOUT-1 with no sensor event SHALL move to FAULT; a sensor event in that same cycle wins.
REQ-028 bottle_drop outside VEND and coin_out outside PAY SHALL be ignored.
REQ-029 A sensor held high for several cycles SHALL count once, since the FSM leaves the state on the first cycle.
REQ-030 FAULT: both drives off; requests still queue per REQ-018/020.
REQ-031 fault_clr in FAULT SHALL clear vend_pend, chg_pend and overflow and go to IDLE; fault_clr elsewhere is ignored.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, motor_on=0, hopper_on=0, busy=0, fault=0, overflow=0, vend_pend=0, chg_pend=0, timer=0, including mid-VEND or mid-PAY.
REQ-033 Requests coincident with rst SHALL be lost.

Structure
REQ-034 Package vend_pkg SHALL hold the state encoding and the PEND_MAX/TIMEOUT defaults shared with the coin FSM.
REQ-035 The timeout counter SHALL be a sub-module vend_timer (inputs clk, rst, restart; output expired), width from $clog2(TIMEOUT).

Verification
REQ-036 One dispense_req with change_req, bottle_drop 3 cycles after motor_on, coin_out 2 cycles after hopper_on -> VEND, PAY, IDLE; counters return to 0; fault=0.
REQ-037 Four dispense_req pulses on consecutive cycles while in IDLE, no sensors -> vend_pend=3, overflow=1.
REQ-038 dispense_req with no bottle_drop -> FAULT exactly TIMEOUT cycles after VEND entry; fault_clr -> IDLE, counters 0.
REQ-039 dispense_req in the same cycle as bottle_drop during VEND with vend_pend=1 -> vend_pend stays 1 and the FSM re-enters VEND via IDLE.
REQ-040 rst pulsed mid-PAY with chg_pend=2 -> hopper_on drops without waiting for clk; all outputs at reset values.
REQ-041 change_req alone, bottle_drop and coin_out in IDLE -> no counter or state change.
